sram_core: RTL and testbench

//  - Single-port synchronous SRAM: 2^ADDR_W words x DATA_W bits; separate data-in and data-out buses.
//  - Controlled by active-low chip-enable (ce_n) and write-enable (we_n), as on an async SRAM part,
//    but sampled on clk.
//  - Local scratch/buffer memory behind a bus master.
//  - Also the behavioural stand-in for an external SRAM device in system simulation.

---
 rtl/sram_core.sv | 71 +++++++
 tb/tb_sram_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_core.sv
// sram_core: single-port synchronous SRAM, 2**ADDR_W words x DATA_W bits.
// The controls ce_n/we_n are active-low, like an asynchronous SRAM part, but
// they are sampled on the rising edge of clk. Read data is registered and
// appears one cycle after the sampling edge, qualified by rd_valid.
// Optional build macro: SRAM_TRISTATE_EN
//   - defined: out_data drives the read register only while ce_n=0 and
//     we_n=1, and floats to Z otherwise (also Z under reset).
//   - undefined: out_data always drives the last value that was read.
// The array itself is never cleared by reset.
module sram_core #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              rd_valid,
  input  logic              ce_n,
  input  logic              we_n
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_out;
  logic              r_rd_valid;
  logic              w_wr_en;
  logic              w_rd_en;

  // Decode the access type. An X or Z on either control makes both
  // comparisons unknown, so neither enable is taken and the cycle is idle.
  always_comb begin
    w_wr_en = (ce_n == 1'b0) && (we_n == 1'b0);
    w_rd_en = (ce_n == 1'b0) && (we_n == 1'b1);
  end

  // Array write and registered read. Reset clears only the output
  // registers; because reset takes priority, an access sampled while rst
  // is high is dropped entirely. A read returns the pre-edge array value,
  // so a write at edge n is visible to a read sampled at edge n+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out      <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[addr] <= in_data;
      end
      if (w_rd_en) begin
        r_out      <= r_mem[addr];
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign rd_valid = r_rd_valid;

`ifdef SRAM_TRISTATE_EN
  // Shared-bus behaviour: drive only while the current controls select a
  // read, combinationally on those controls.
  assign out_data = (!rst && w_rd_en) ? r_out : {DATA_W{1'bz}};
`else
  // Point-to-point behaviour: always drive the last read value.
  assign out_data = r_out;
`endif

endmodule

// File: tb/tb_sram_core.sv
// Testbench for sram_core: directed scenarios followed by a randomized run,
// all checked against an associative-array memory model.
module tb_sram_core;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic              rd_valid;
  logic              ce_n;
  logic              we_n;

  int checks;
  int failures;

  // Reference model: contents of every written location, plus the value
  // the output register should currently hold.
  logic [DATA_W-1:0] m_mem [int];
  logic [DATA_W-1:0] m_out;
  bit                m_out_known;
  int                wr_list[$];

  sram_core #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .in_data  (in_data),
    .out_data (out_data),
    .rd_valid (rd_valid),
    .ce_n     (ce_n),
    .we_n     (we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one access, clock it, then compare against the model 1 ns after
  // the edge (controls still held, which matters for the tri-state build).
  task automatic step(input string tag, input logic c, input logic w,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic exp_rv;
    logic [DATA_W-1:0] exp_od;
    ce_n    = c;
    we_n    = w;
    addr    = a;
    in_data = d;
    exp_rv  = 1'b0;
    if (!c && !w) begin
      m_mem[int'(a)] = d;
      wr_list.push_back(int'(a));
    end else if (!c && w) begin
      exp_rv = 1'b1;
      if (m_mem.exists(int'(a))) begin
        m_out       = m_mem[int'(a)];
        m_out_known = 1'b1;
      end else begin
        m_out_known = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".rd_valid"}, {7'd0, rd_valid}, {7'd0, exp_rv});
`ifdef SRAM_TRISTATE_EN
    if (!(!c && w)) begin
      exp_od = {DATA_W{1'bz}};
      check({tag, ".out_data"}, out_data, exp_od);
    end else if (m_out_known) begin
      exp_od = m_out;
      check({tag, ".out_data"}, out_data, exp_od);
    end
`else
    if (m_out_known) begin
      exp_od = m_out;
      check({tag, ".out_data"}, out_data, exp_od);
    end
`endif
  endtask

  initial begin
    logic [DATA_W-1:0] zero8;
    logic [DATA_W-1:0] exp_od;
    int                n;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    int                kind;

    checks      = 0;
    failures    = 0;
    zero8       = '0;
    m_out       = '0;
    m_out_known = 1'b1;
    rst         = 1'b1;
    ce_n        = 1'b1;
    we_n        = 1'b1;
    addr        = '0;
    in_data     = '0;

    // Reset state.
    #12;
`ifdef SRAM_TRISTATE_EN
    exp_od = {DATA_W{1'bz}};
`else
    exp_od = zero8;
`endif
    check("reset.out_data", out_data, exp_od);
    check("reset.rd_valid", {7'd0, rd_valid}, zero8);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Writes of 61/62/63: no read strobe, output unchanged.
    step("wr61", 1'b0, 1'b0, 18'd61, 8'd61);
    step("wr62", 1'b0, 1'b0, 18'd62, 8'd62);
    step("wr63", 1'b0, 1'b0, 18'd63, 8'd63);
    step("idle_after_wr", 1'b1, 1'b0, 18'd61, 8'hFF);

    // Back-to-back reads stream one word per cycle.
    step("rd61", 1'b0, 1'b1, 18'd61, 8'hEE);
    step("rd62", 1'b0, 1'b1, 18'd62, 8'hEE);
    step("rd63", 1'b0, 1'b1, 18'd63, 8'hEE);

    // Write then immediately read the same address.
    step("wr_b2b", 1'b0, 1'b0, 18'd100, 8'h3C);
    step("rd_b2b", 1'b0, 1'b1, 18'd100, 8'h00);

    // Address extremes do not alias.
    step("wr_a0",   1'b0, 1'b0, 18'd0, 8'h5A);
    step("wr_atop", 1'b0, 1'b0, TOP_ADDR, 8'hA5);
    step("rd_atop", 1'b0, 1'b1, TOP_ADDR, 8'h00);
    step("rd_a0",   1'b0, 1'b1, 18'd0, 8'h00);

    // Write sampled at the same edge as reset is discarded.
    ce_n    = 1'b0;
    we_n    = 1'b0;
    addr    = 18'd62;
    in_data = 8'h55;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    check("rst_edge.rd_valid", {7'd0, rd_valid}, zero8);
    rst   = 1'b0;
    m_out = '0;
    m_out_known = 1'b1;
    step("rd62_after_rst", 1'b0, 1'b1, 18'd62, 8'h00);

    // Mid-cycle reset pulse clears outputs with no clock edge.
    step("rd61_pre_pulse", 1'b0, 1'b1, 18'd61, 8'h00);
    #2;
    rst = 1'b1;
    #1;
`ifdef SRAM_TRISTATE_EN
    exp_od = {DATA_W{1'bz}};
`else
    exp_od = zero8;
`endif
    check("rst_pulse.out_data", out_data, exp_od);
    check("rst_pulse.rd_valid", {7'd0, rd_valid}, zero8);
    #1;
    rst   = 1'b0;
    m_out = '0;
    m_out_known = 1'b1;
    @(posedge clk);
    #1;

    // Read 61 then go idle: hold (or float in the tri-state build).
    step("rd61_hold", 1'b0, 1'b1, 18'd61, 8'h00);
    step("idle_hold", 1'b1, 1'b1, 18'd61, 8'h00);
`ifdef SRAM_TRISTATE_EN
    exp_od = {DATA_W{1'bz}};
`else
    exp_od = 8'd61;
`endif
    check("idle_hold.explicit", out_data, exp_od);

    // Randomized traffic over a small address pool plus the extremes.
    for (n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      rd   = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       ra = 18'd0;
        1:       ra = TOP_ADDR;
        default: ra = 18'($urandom_range(0, 15) + 32);
      endcase
      if (kind < 4) begin
        step("rnd_wr", 1'b0, 1'b0, ra, rd);
      end else if (kind < 8 && wr_list.size() > 0) begin
        ra = 18'(wr_list[$urandom_range(0, wr_list.size() - 1)]);
        step("rnd_rd", 1'b0, 1'b1, ra, rd);
      end else begin
        step("rnd_idle", 1'b1, 1'($urandom), ra, rd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
